// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage of the pipelined MIPS core.
//   - PC source select encodings driven by the PC-source resolver.
//   - Fetch sequencer state type.
//   - Default reset PC.
//   - Helper that decides whether a select value is a redirect.
package cpu_pkg;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_RSV = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // The reserved encoding behaves as sequential, so only BR and JMP redirect.
  function automatic logic pcs_is_redirect(input logic [1:0] sel);
    return (sel == PCS_BR) || (sel == PCS_JMP);
  endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// Single-entry redirect buffer for the fetch stage.
// Remembers a redirect that arrived while an I-cache request was still
// outstanding, so it can be applied once that request completes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   set         : capture set_addr as the pending redirect (newest wins)
//   set_addr    : redirect target to capture
//   clr         : consume the pending redirect
//   pend        : a redirect is pending
//   addr        : pending redirect target
module fetch_redirect_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic [31:0] set_addr,
  input  logic        clr,
  output logic        pend,
  output logic [31:0] addr
);

  logic        pend_reg;
  logic [31:0] addr_reg;

  // A fresh redirect takes priority over consumption so that a redirect can
  // never be lost, even if both were ever requested in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= 1'b0;
      addr_reg <= '0;
    end else if (set) begin
      pend_reg <= 1'b1;
      addr_reg <= set_addr;
    end else if (clr) begin
      pend_reg <= 1'b0;
    end
  end

  assign pend = pend_reg;
  assign addr = addr_reg;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the architectural PC, issues I-cache fetches with a
// hold-until-ready handshake and fills the IF/ID slot.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   pc_source_ctrl             : 00 seq, 01 branch, 10 jump, 11 treated as seq
//   branch_target, jump_target : redirect targets
//   hazard_stall               : IF/ID must hold its contents
//   icache_req, icache_addr    : fetch request and word address
//   icache_ready, icache_rdata : request completes with this instruction word
//   if_valid, if_pc, if_pc_plus4, if_instr : IF/ID slot contents
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_source_ctrl,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        hazard_stall,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic [31:0] icache_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  skid_pc_reg, skid_instr_reg;
  logic         if_valid_reg, if_valid_next;
  logic [31:0]  if_pc_reg, if_pc_plus4_reg, if_instr_reg;

  logic         redirect;
  logic [31:0]  target;
  logic         slot_free;
  logic         load_fetch;   // IF/ID takes the word returning from the cache
  logic         load_skid;    // IF/ID takes the parked word
  logic         skid_wr;      // park the returning word
  logic         buf_set, buf_clr;
  logic         redir_pend;
  logic [31:0]  redir_addr;

  assign redirect  = pcs_is_redirect(pc_source_ctrl);
  assign target    = (pc_source_ctrl == PCS_BR) ? branch_target : jump_target;
  assign slot_free = !if_valid_reg || !hazard_stall;

  fetch_redirect_buf u_redir (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (buf_set),
    .set_addr (target),
    .clr      (buf_clr),
    .pend     (redir_pend),
    .addr     (redir_addr)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    load_fetch = 1'b0;
    load_skid  = 1'b0;
    skid_wr    = 1'b0;
    buf_set    = 1'b0;
    buf_clr    = 1'b0;
    // Without new data the slot empties once downstream takes it, and holds
    // while stalled. A redirect flushes it regardless of the stall.
    if_valid_next = if_valid_reg && hazard_stall;
    if (redirect) begin
      if_valid_next = 1'b0;
    end

    unique case (state_reg)
      BOOT: begin
        // A redirect seen during boot becomes the very first fetch address,
        // so no request is ever sent to RESET_PC in that case.
        state_next = REQ;
        if (redirect) begin
          pc_next = target;
        end
      end

      REQ: begin
        if (icache_ready) begin
          if (redirect || redir_pend) begin
            // The returning word is on the wrong path; drop it.
            pc_next = redirect ? target : redir_addr;
            buf_clr = 1'b1;
          end else if (slot_free) begin
            load_fetch    = 1'b1;
            if_valid_next = 1'b1;
            pc_next       = pc_reg + PC_INC;
          end else begin
            skid_wr    = 1'b1;
            pc_next    = pc_reg + PC_INC;
            state_next = HOLD;
          end
        end else if (redirect) begin
          // Request in flight: keep the address stable, remember the redirect.
          buf_set = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = REQ;
        end else if (!hazard_stall) begin
          load_skid     = 1'b1;
          if_valid_next = 1'b1;
          state_next    = REQ;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      skid_pc_reg     <= '0;
      skid_instr_reg  <= '0;
      if_valid_reg    <= 1'b0;
      if_pc_reg       <= '0;
      if_pc_plus4_reg <= '0;
      if_instr_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      if_valid_reg <= if_valid_next;
      if (skid_wr) begin
        skid_pc_reg    <= pc_reg;
        skid_instr_reg <= icache_rdata;
      end
      if (load_fetch) begin
        if_pc_reg       <= pc_reg;
        if_pc_plus4_reg <= pc_reg + PC_INC;
        if_instr_reg    <= icache_rdata;
      end else if (load_skid) begin
        if_pc_reg       <= skid_pc_reg;
        if_pc_plus4_reg <= skid_pc_reg + PC_INC;
        if_instr_reg    <= skid_instr_reg;
      end
    end
  end

  // Request is a pure function of state so an asynchronous reset drops it
  // immediately; the address is the PC, which only moves on completion.
  assign icache_req  = (state_reg == REQ);
  assign icache_addr = pc_reg;
  assign if_valid    = if_valid_reg;
  assign if_pc       = if_pc_reg;
  assign if_pc_plus4 = if_pc_plus4_reg;
  assign if_instr    = if_instr_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based behavioural model of the fetch stage.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_source_ctrl;
  logic [31:0] branch_target, jump_target;
  logic        hazard_stall;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_pc_plus4, if_instr;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_source_ctrl (pc_source_ctrl),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .hazard_stall   (hazard_stall),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_ready   (icache_ready),
    .icache_rdata   (icache_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory content: every word is a distinct function of its address.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  bit          m_started;     // boot cycle has elapsed
  logic [31:0] m_pc;          // next address to fetch
  bit          m_pend;
  logic [31:0] m_pend_addr;
  word_t       parked[$];     // fetched but not yet delivered (at most one)
  bit          m_valid;
  word_t       m_out;

  task automatic model_reset();
    m_started   = 0;
    m_pc        = 32'h0;
    m_pend      = 0;
    m_pend_addr = 32'h0;
    parked.delete();
    m_valid     = 0;
    m_out       = '0;
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    bit          redir;
    logic [31:0] tgt;
    redir = (pc_source_ctrl == 2'b01) || (pc_source_ctrl == 2'b10);
    tgt   = (pc_source_ctrl == 2'b01) ? branch_target : jump_target;
    if (!m_started) begin
      m_started = 1;
      if (redir) m_pc = tgt;
    end else if (parked.size() != 0) begin
      if (redir) begin
        parked.delete();
        m_pc    = tgt;
        m_valid = 0;
      end else if (!hazard_stall) begin
        m_out   = parked.pop_front();
        m_valid = 1;
      end
    end else if (icache_ready) begin
      if (redir || m_pend) begin
        m_pc    = redir ? tgt : m_pend_addr;
        m_pend  = 0;
        m_valid = redir ? 0 : (m_valid && hazard_stall);
      end else if (!m_valid || !hazard_stall) begin
        m_out   = '{pc: m_pc, instr: tag(m_pc)};
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
      end else begin
        parked.push_back('{pc: m_pc, instr: tag(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (redir) begin
        m_pend      = 1;
        m_pend_addr = tgt;
        m_valid     = 0;
      end else begin
        m_valid = m_valid && hazard_stall;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit exp_req;
    exp_req = m_started && (parked.size() == 0);
    chk("icache_req", {31'b0, icache_req}, {31'b0, exp_req});
    if (exp_req) chk("icache_addr", icache_addr, m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("if_pc", if_pc, m_out.pc);
      chk("if_pc_plus4", if_pc_plus4, m_out.pc + 32'd4);
      chk("if_instr", if_instr, m_out.instr);
    end
  endtask

  bit verbose = 1;

  // One transaction: apply inputs at the falling edge, advance the model,
  // then check the DUT at the next falling edge.
  task automatic tick(input logic [1:0] ctrl, input logic [31:0] br, input logic [31:0] jt,
                      input logic stall, input logic rdy);
    pc_source_ctrl = ctrl;
    branch_target  = br;
    jump_target    = jt;
    hazard_stall   = stall;
    icache_ready   = rdy;
    icache_rdata   = tag(icache_addr);
    model_step();
    @(negedge clk);
    compare_model();
    if (verbose)
      $display("txn ctrl=%b stall=%b rdy=%b -> req=%b addr=%08h valid=%b if_pc=%08h",
               ctrl, stall, rdy, icache_req, icache_addr, if_valid, if_pc);
  endtask

  initial begin
    rst_n          = 1'b0;
    pc_source_ctrl = PCS_SEQ;
    branch_target  = '0;
    jump_target    = '0;
    hazard_stall   = 1'b0;
    icache_ready   = 1'b0;
    icache_rdata   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    compare_model();
    chk("rst_req", {31'b0, icache_req}, 32'd0);
    chk("rst_addr", icache_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_plus4", if_pc_plus4, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);

    // Back-to-back hits from reset.
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("first_req", {31'b0, icache_req}, 32'd1);
    chk("first_addr", icache_addr, 32'h0);
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("hit0_pc", if_pc, 32'h0);
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("hit1_pc", if_pc, 32'h4);
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("hit2_pc", if_pc, 32'h8);
    chk("hit2_plus4", if_pc_plus4, 32'hC);
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("pre_miss_addr", icache_addr, 32'h10);

    // Five-cycle miss at 0x10.
    for (int i = 0; i < 5; i++) begin
      tick(PCS_SEQ, 0, 0, 0, 0);
      chk("miss_addr", icache_addr, 32'h10);
      chk("miss_valid", {31'b0, if_valid}, 32'd0);
    end
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("miss_done_pc", if_pc, 32'h10);
    chk("miss_done_valid", {31'b0, if_valid}, 32'd1);
    repeat (3) tick(PCS_SEQ, 0, 0, 0, 1);
    chk("seq_addr_20", icache_addr, 32'h20);

    // Branch during a miss: the 0x20 word must be discarded.
    tick(PCS_BR, 32'h100, 0, 0, 0);
    chk("br_miss_addr", icache_addr, 32'h20);
    chk("br_miss_valid", {31'b0, if_valid}, 32'd0);
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("br_discard_valid", {31'b0, if_valid}, 32'd0);
    chk("br_new_addr", icache_addr, 32'h100);

    // Jump to 0x40, then stall with a parked word.
    tick(PCS_JMP, 0, 32'h40, 0, 1);
    chk("jmp_addr", icache_addr, 32'h40);
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("j40_pc", if_pc, 32'h40);
    tick(PCS_SEQ, 0, 0, 1, 1);
    chk("hold_req", {31'b0, icache_req}, 32'd0);
    chk("hold_pc", if_pc, 32'h40);
    tick(PCS_SEQ, 0, 0, 1, 1);
    chk("hold2_pc", if_pc, 32'h40);
    tick(PCS_SEQ, 0, 0, 0, 0);
    chk("unpark_pc", if_pc, 32'h44);
    chk("unpark_addr", icache_addr, 32'h48);

    // Park again, then jump while stalled: skid dropped, slot flushed.
    tick(PCS_SEQ, 0, 0, 1, 1);
    chk("hold3_req", {31'b0, icache_req}, 32'd0);
    tick(PCS_JMP, 0, 32'h200, 1, 0);
    chk("flush_valid", {31'b0, if_valid}, 32'd0);
    chk("flush_addr", icache_addr, 32'h200);

    // Reserved select behaves as sequential.
    tick(PCS_RSV, 32'h300, 32'h400, 0, 1);
    chk("rsv_pc", if_pc, 32'h200);
    chk("rsv_addr", icache_addr, 32'h204);

    // Wrap-around.
    tick(PCS_JMP, 0, 32'hFFFF_FFFC, 0, 1);
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", if_pc_plus4, 32'h0);
    chk("wrap_addr", icache_addr, 32'h0);

    // Asynchronous reset in the middle of a miss with a valid slot.
    tick(PCS_SEQ, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, icache_req}, 32'd0);
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    model_reset();
    icache_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_model();

    // Redirect during boot becomes the first fetch address.
    tick(PCS_BR, 32'h80, 0, 0, 1);
    chk("boot_redir_addr", icache_addr, 32'h80);
    chk("boot_redir_req", {31'b0, icache_req}, 32'd1);
    tick(PCS_SEQ, 0, 0, 0, 1);
    chk("boot_redir_pc", if_pc, 32'h80);

    // Randomized traffic.
    verbose = 0;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [1:0]  c;
      logic [31:0] bt, jt;
      r = $urandom_range(0, 99);
      if (r < 8)       c = PCS_BR;
      else if (r < 14) c = PCS_JMP;
      else if (r < 18) c = PCS_RSV;
      else             c = PCS_SEQ;
      bt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      jt = ($urandom_range(0, 15) == 0) ? $urandom() : ($urandom() & 32'h0000_FFFC);
      tick(c, bt, jt, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
